// File: rtl/jtkicker_vtgen_pkg.sv
// jtkicker_vtgen_pkg
// Shared timing constants for the video timing generator (384x264 total
// raster) and the inclusive, wrap-aware window test used for the blank and
// sync windows.
package jtkicker_vtgen_pkg;

  localparam int DEF_W        = 9;
  localparam int DEF_HCNT_END = 383;
  localparam int DEF_VCNT_END = 263;
  localparam int DEF_HB_START = 255;
  localparam int DEF_HB_END   = 383;
  localparam int DEF_HS_START = 300;
  localparam int DEF_HS_END   = 318;
  localparam int DEF_VB_START = 239;
  localparam int DEF_VB_END   = 15;
  localparam int DEF_VS_START = 254;
  localparam int DEF_VS_END   = 2;

  // Window [s,e] is inclusive. When s > e it wraps through 0, and when
  // s == e it is exactly one count wide.
  function automatic logic in_window(input int v, input int s, input int e);
    if (s <= e) return (v >= s) && (v <= e);
    else        return (v >= s) || (v <= e);
  endfunction

endpackage

// File: rtl/jtkicker_vtgen_if.sv
// jtkicker_vtgen_if
// Bundles the timing generator's pixel-rate controls and its raster outputs.
//   master (generator side): in pxl_cen, flip, irq_line;
//                            out hdump, vdump, vrender, vdump_f, hinit,
//                                vinit, LHBL, LVBL, HS, VS, line_irq
//   slave  (consumer side): the mirror image.
// Handshake: there is no valid/ready pair. pxl_cen is a per-clock qualifier:
// the generator advances on a clk edge only when pxl_cen=1 and otherwise
// holds every output; line_irq is a single-clk strobe.
interface jtkicker_vtgen_if #(
  parameter int W = 9
);
  logic         pxl_cen;
  logic         flip;
  logic [W-1:0] irq_line;
  logic [W-1:0] hdump;
  logic [W-1:0] vdump;
  logic [W-1:0] vrender;
  logic [W-1:0] vdump_f;
  logic         hinit;
  logic         vinit;
  logic         LHBL;
  logic         LVBL;
  logic         HS;
  logic         VS;
  logic         line_irq;

  modport master (
    input  pxl_cen, flip, irq_line,
    output hdump, vdump, vrender, vdump_f, hinit, vinit,
           LHBL, LVBL, HS, VS, line_irq
  );

  modport slave (
    output pxl_cen, flip, irq_line,
    input  hdump, vdump, vrender, vdump_f, hinit, vinit,
           LHBL, LVBL, HS, VS, line_irq
  );
endinterface

// File: rtl/jtkicker_vtgen_cnt.sv
// jtkicker_vtgen_cnt
// One wrapping counter 0..END_VAL, used for both the horizontal and the
// vertical raster position.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_cen      : advance enable
//   o_cnt      : current count
//   o_nxt      : value the count takes on the next clk edge
//   o_end      : count is at END_VAL
module jtkicker_vtgen_cnt #(
  parameter int W       = 9,
  parameter int END_VAL = 383
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cen,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_end
);
  localparam logic [W-1:0] END_W = END_VAL[W-1:0];
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  assign o_end = (r_cnt == END_W);
  assign o_cnt = r_cnt;

  always_comb begin
    o_nxt = r_cnt;
    if (i_cen) o_nxt = o_end ? '0 : r_cnt + ONE_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= o_nxt;
  end
endmodule

// File: rtl/jtkicker_vtgen.sv
// jtkicker_vtgen
// Video timing generator: horizontal/vertical raster counters, blanking and
// sync strobes, next-line render index, flip-adjusted line number and an
// optional programmable line interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   vt         : jtkicker_vtgen_if.master (pxl_cen, flip, irq_line in;
//                raster position and strobes out)
// Optional feature: define JTKICKER_VTGEN_LINEIRQ_EN to build the irq_line
// shadow register and the line_irq pulse; otherwise line_irq is tied low.
module jtkicker_vtgen
  import jtkicker_vtgen_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int HCNT_END = DEF_HCNT_END,
  parameter int VCNT_END = DEF_VCNT_END,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END   = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END   = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtkicker_vtgen_if.master       vt
);
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] VEND_W = VCNT_END[W-1:0];
  localparam logic [W-1:0] HS_W   = HS_START[W-1:0];

  logic [W-1:0] w_h_cnt, w_h_nxt, w_v_cnt, w_v_nxt;
  logic         w_h_end, w_v_end, w_v_cen;
  logic [W-1:0] r_vrender;
  logic         r_lhbl, r_lvbl, r_hs, r_vs;

  // The vertical counter steps once per line, on the horizontal wrap.
  assign w_v_cen = vt.pxl_cen & w_h_end;

  jtkicker_vtgen_cnt #(.W(W), .END_VAL(HCNT_END)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_cen (vt.pxl_cen),
    .o_cnt (w_h_cnt),
    .o_nxt (w_h_nxt),
    .o_end (w_h_end)
  );

  jtkicker_vtgen_cnt #(.W(W), .END_VAL(VCNT_END)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_cen (w_v_cen),
    .o_cnt (w_v_cnt),
    .o_nxt (w_v_nxt),
    .o_end (w_v_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vrender <= ONE_W;
    end else if (w_v_cen) begin
      r_vrender <= (w_v_nxt == VEND_W) ? '0 : w_v_nxt + ONE_W;
    end
  end

  // Strobes are registered from the counters' next values so that each
  // strobe lines up with the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lhbl <= 1'b0;
      r_lvbl <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
    end else if (vt.pxl_cen) begin
      r_lhbl <= ~in_window(32'(w_h_nxt), HB_START, HB_END);
      r_lvbl <= ~in_window(32'(w_v_nxt), VB_START, VB_END);
      r_hs   <=  in_window(32'(w_h_nxt), HS_START, HS_END);
      // VS only re-evaluates as the line enters horizontal sync.
      if (w_h_nxt == HS_W) r_vs <= in_window(32'(w_v_nxt), VS_START, VS_END);
    end
  end

  assign vt.hdump   = w_h_cnt;
  assign vt.vdump   = w_v_cnt;
  assign vt.vrender = r_vrender;
  assign vt.vdump_f = vt.flip ? ~w_v_cnt : w_v_cnt;
  assign vt.hinit   = w_h_end;
  assign vt.vinit   = w_h_end & w_v_end;
  assign vt.LHBL    = r_lhbl;
  assign vt.LVBL    = r_lvbl;
  assign vt.HS      = r_hs;
  assign vt.VS      = r_vs;

`ifdef JTKICKER_VTGEN_LINEIRQ_EN
  localparam logic [W-1:0] HB_W = HB_START[W-1:0];

  logic [W-1:0] r_shadow;
  logic         r_line_irq;

  // irq_line is latched only at the frame boundary, so writes made during a
  // frame apply to the following frame. A shadow beyond VCNT_END never
  // matches vdump and therefore never fires. The strobe lasts a single clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_line_irq <= 1'b0;
    end else begin
      r_line_irq <= vt.pxl_cen && (w_h_nxt == HB_W) && (w_v_nxt == r_shadow);
      if (vt.pxl_cen && w_h_end && w_v_end) r_shadow <= vt.irq_line;
    end
  end

  assign vt.line_irq = r_line_irq;
`else
  logic w_unused_irq_line;
  assign w_unused_irq_line = ^vt.irq_line;
  assign vt.line_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_jtkicker_vtgen.sv
// tb_jtkicker_vtgen
// Two instances: u_big uses the default 384x264 raster for reset, line,
// hold and flip checks; u_small uses a reduced 48x33 raster so that several
// whole frames (vinit, LVBL, VS, line interrupt) fit in a short run. The
// small instance is checked every pixel against a behavioural model through
// an expected queue.
module tb_jtkicker_vtgen;

  // small raster geometry
  localparam int S_HE  = 47;
  localparam int S_VE  = 32;
  localparam int S_HB0 = 31, S_HB1 = 47;
  localparam int S_HS0 = 37, S_HS1 = 39;
  localparam int S_VB0 = 29, S_VB1 = 1;
  localparam int S_VS0 = 31, S_VS1 = 1;
  localparam int S_FRAME = (S_HE + 1) * (S_VE + 1);

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  jtkicker_vtgen_if #(.W(9)) big_if ();
  jtkicker_vtgen_if #(.W(9)) small_if ();

  jtkicker_vtgen u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .vt    (big_if)
  );

  jtkicker_vtgen #(
    .W(9), .HCNT_END(S_HE), .VCNT_END(S_VE),
    .HB_START(S_HB0), .HB_END(S_HB1), .HS_START(S_HS0), .HS_END(S_HS1),
    .VB_START(S_VB0), .VB_END(S_VB1), .VS_START(S_VS0), .VS_END(S_VS1)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vt    (small_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- model / scoreboard ----------------
  logic [33:0] exp_q[$];
  int   m_h, m_v, m_shadow;
  logic m_vs;

  function automatic logic win(input int v, input int s, input int e);
    if (s <= e) return (v >= s) && (v <= e);
    return (v >= s) || (v <= e);
  endfunction

  function automatic logic [33:0] pack_small();
    return {small_if.hdump, small_if.vdump, small_if.vrender, small_if.hinit,
            small_if.vinit, small_if.LHBL, small_if.LVBL, small_if.HS,
            small_if.VS, small_if.line_irq};
  endfunction

  function automatic logic [42:0] pack_big();
    return {big_if.hdump, big_if.vdump, big_if.vrender, big_if.vdump_f,
            big_if.hinit, big_if.vinit, big_if.LHBL, big_if.LVBL, big_if.HS,
            big_if.VS, big_if.line_irq};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_shadow = 0; m_vs = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one pixel and queue the outputs expected after it.
  task automatic model_advance();
    logic h_end, vi, irq;
    int   nh, nv, nr;
    h_end = (m_h == S_HE);
    vi    = h_end && (m_v == S_VE);
    nh    = h_end ? 0 : m_h + 1;
    nv    = h_end ? ((m_v == S_VE) ? 0 : m_v + 1) : m_v;
    nr    = (nv == S_VE) ? 0 : nv + 1;
`ifdef JTKICKER_VTGEN_LINEIRQ_EN
    irq   = (nh == S_HB0) && (nv == m_shadow);
    if (vi) m_shadow = int'(small_if.irq_line);
`else
    irq   = 1'b0;
`endif
    if (nh == S_HS0) m_vs = win(nv, S_VS0, S_VS1);
    exp_q.push_back({9'(nh), 9'(nv), 9'(nr), (nh == S_HE),
                     (nh == S_HE) && (nv == S_VE), !win(nh, S_HB0, S_HB1),
                     !win(nv, S_VB0, S_VB1), win(nh, S_HS0, S_HS1), m_vs, irq});
    m_h = nh;
    m_v = nv;
  endtask

  // ---------------- driver tasks ----------------
  task automatic big_step(input logic cen);
    @(negedge clk);
    big_if.pxl_cen = cen;
    @(posedge clk);
    #1;
  endtask

  task automatic small_step();
    logic [33:0] exp, got;
    @(negedge clk);
    small_if.pxl_cen = 1'b1;
    model_advance();
    @(posedge clk);
    #1;
    total++;
    got = pack_small();
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL small_sb: got=%h with no expected entry", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        bad++;
        $display("FAIL small_sb at h=%0d v=%0d: got=%h exp=%h", m_h, m_v, got, exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    big_if.pxl_cen   = 1'b0;
    small_if.pxl_cen = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    big_if.pxl_cen   = 1'b1;
    small_if.pxl_cen = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (big_if.hdump !== 9'd0) begin bad++; $display("FAIL rst_hdump got=%0d exp=0", big_if.hdump); end
    total++; if (big_if.vdump !== 9'd0) begin bad++; $display("FAIL rst_vdump got=%0d exp=0", big_if.vdump); end
    total++; if (big_if.vrender !== 9'd1) begin bad++; $display("FAIL rst_vrender got=%0d exp=1", big_if.vrender); end
    total++;
    if ({big_if.hinit, big_if.vinit, big_if.LHBL, big_if.LVBL, big_if.HS, big_if.VS, big_if.line_irq} !== 7'd0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=0000000",
               {big_if.hinit, big_if.vinit, big_if.LHBL, big_if.LVBL, big_if.HS, big_if.VS, big_if.line_irq});
    end
    total++; if (small_if.vrender !== 9'd1) begin bad++; $display("FAIL rst_small_vrender got=%0d exp=1", small_if.vrender); end
    @(negedge clk);
    big_if.pxl_cen   = 1'b0;
    small_if.pxl_cen = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_hcount();
    big_step(1'b1);
    total++; if (big_if.hdump !== 9'd1) begin bad++; $display("FAIL first_cen_hdump got=%0d exp=1", big_if.hdump); end
    repeat (382) big_step(1'b1);
    total++; if (big_if.hdump !== 9'd383) begin bad++; $display("FAIL hend_hdump got=%0d exp=383", big_if.hdump); end
    total++; if (big_if.hinit !== 1'b1) begin bad++; $display("FAIL hend_hinit got=%b exp=1", big_if.hinit); end
    total++; if (big_if.vdump !== 9'd0) begin bad++; $display("FAIL hend_vdump got=%0d exp=0", big_if.vdump); end
    big_step(1'b1);
    total++; if (big_if.hdump !== 9'd0) begin bad++; $display("FAIL hwrap_hdump got=%0d exp=0", big_if.hdump); end
    total++; if (big_if.vdump !== 9'd1) begin bad++; $display("FAIL hwrap_vdump got=%0d exp=1", big_if.vdump); end
    total++; if (big_if.vrender !== 9'd2) begin bad++; $display("FAIL hwrap_vrender got=%0d exp=2", big_if.vrender); end
    total++; if (big_if.hinit !== 1'b0) begin bad++; $display("FAIL hwrap_hinit got=%b exp=0", big_if.hinit); end
  endtask

  task automatic test_hsync();
    int hs_n = 0, hs_first = -1, hb_n = 0, hb_first = -1;
    for (int i = 0; i < 384; i++) begin
      big_step(1'b1);
      if (big_if.HS === 1'b1) begin
        if (hs_first < 0) hs_first = int'(big_if.hdump);
        hs_n++;
      end
      if (big_if.LHBL === 1'b0) begin
        if (hb_first < 0) hb_first = int'(big_if.hdump);
        hb_n++;
      end
    end
    total++; if (hs_n != 19) begin bad++; $display("FAIL hs_width got=%0d exp=19", hs_n); end
    total++; if (hs_first != 300) begin bad++; $display("FAIL hs_start got=%0d exp=300", hs_first); end
    total++; if (hb_n != 129) begin bad++; $display("FAIL hb_width got=%0d exp=129", hb_n); end
    total++; if (hb_first != 255) begin bad++; $display("FAIL hb_start got=%0d exp=255", hb_first); end
  endtask

  task automatic test_hold_flip();
    // at h=100, v=2: vblank active, VS high since line 0, LHBL high
    logic [42:0] exp_hold;
    exp_hold = {9'd100, 9'd2, 9'd3, 9'd2, 7'b0010010};
    repeat (100) big_step(1'b1);
    for (int i = 0; i < 10; i++) begin
      big_step(1'b0);
      total++;
      if (pack_big() !== exp_hold) begin
        bad++;
        $display("FAIL hold_%0d got=%h exp=%h", i, pack_big(), exp_hold);
      end
    end
    repeat (284 + 12 * 384) big_step(1'b1);
    total++; if (big_if.vdump !== 9'd15 || big_if.LVBL !== 1'b0) begin
      bad++; $display("FAIL vb_end vdump=%0d LVBL=%b exp 15/0", big_if.vdump, big_if.LVBL);
    end
    repeat (384) big_step(1'b1);
    total++; if (big_if.vdump !== 9'd16 || big_if.LVBL !== 1'b1) begin
      bad++; $display("FAIL vb_exit vdump=%0d LVBL=%b exp 16/1", big_if.vdump, big_if.LVBL);
    end
    total++; if (big_if.VS !== 1'b0) begin bad++; $display("FAIL vs_low_v16 got=%b exp=0", big_if.VS); end
    total++; if (big_if.vrender !== 9'd17) begin bad++; $display("FAIL vrender_v16 got=%0d exp=17", big_if.vrender); end
    big_if.flip = 1'b1;
    #1;
    total++; if (big_if.vdump_f !== 9'd495) begin bad++; $display("FAIL flip_on got=%0d exp=495", big_if.vdump_f); end
    big_if.flip = 1'b0;
    #1;
    total++; if (big_if.vdump_f !== 9'd16) begin bad++; $display("FAIL flip_off got=%0d exp=16", big_if.vdump_f); end
  endtask

  // one frame of the small raster, optionally rewriting irq_line at (0,chg_v)
  int f_irq_n, f_irq_h, f_irq_v, f_vi_n, f_vi_h, f_vi_v, f_lvbl0, f_hs;
  int f_rise_h, f_rise_v, f_fall_h, f_fall_v;

  task automatic run_frame(input int chg_v, input logic [8:0] chg_val);
    logic prev_vs;
    f_irq_n = 0; f_irq_h = -1; f_irq_v = -1; f_vi_n = 0; f_vi_h = -1; f_vi_v = -1;
    f_lvbl0 = 0; f_hs = 0; f_rise_h = -1; f_rise_v = -1; f_fall_h = -1; f_fall_v = -1;
    prev_vs = small_if.VS;
    for (int i = 0; i < S_FRAME; i++) begin
      if (m_v == chg_v && m_h == 0) small_if.irq_line = chg_val;
      small_step();
      if (small_if.line_irq === 1'b1) begin
        f_irq_n++; f_irq_h = int'(small_if.hdump); f_irq_v = int'(small_if.vdump);
      end
      if (small_if.vinit === 1'b1) begin
        f_vi_n++; f_vi_h = int'(small_if.hdump); f_vi_v = int'(small_if.vdump);
      end
      if (small_if.LVBL === 1'b0) f_lvbl0++;
      if (small_if.HS === 1'b1) f_hs++;
      if (small_if.VS === 1'b1 && prev_vs === 1'b0) begin
        f_rise_h = int'(small_if.hdump); f_rise_v = int'(small_if.vdump);
      end
      if (small_if.VS === 1'b0 && prev_vs === 1'b1) begin
        f_fall_h = int'(small_if.hdump); f_fall_v = int'(small_if.vdump);
      end
      prev_vs = small_if.VS;
    end
  endtask

  task automatic test_frame();
    do_reset();
    small_if.irq_line = 9'd12;
    run_frame(-1, 9'd0);
    run_frame(10, 9'd6);
    total++; if (f_vi_n != 1 || f_vi_h != S_HE || f_vi_v != S_VE) begin
      bad++; $display("FAIL vinit n=%0d at h=%0d v=%0d exp 1 at 47/32", f_vi_n, f_vi_h, f_vi_v);
    end
    total++; if (f_lvbl0 != 6 * 48) begin bad++; $display("FAIL lvbl_lines got=%0d exp=288", f_lvbl0); end
    total++; if (f_hs != 33 * 3) begin bad++; $display("FAIL hs_frame got=%0d exp=99", f_hs); end
    total++; if (f_rise_h != S_HS0 || f_rise_v != S_VS0) begin
      bad++; $display("FAIL vs_rise at h=%0d v=%0d exp 37/31", f_rise_h, f_rise_v);
    end
    total++; if (f_fall_h != S_HS0 || f_fall_v != 2) begin
      bad++; $display("FAIL vs_fall at h=%0d v=%0d exp 37/2", f_fall_h, f_fall_v);
    end
`ifdef JTKICKER_VTGEN_LINEIRQ_EN
    total++; if (f_irq_n != 1 || f_irq_h != S_HB0 || f_irq_v != 12) begin
      bad++; $display("FAIL irq_12 n=%0d at h=%0d v=%0d exp 1 at 31/12", f_irq_n, f_irq_h, f_irq_v);
    end
    run_frame(10, 9'd40);
    total++; if (f_irq_n != 1 || f_irq_h != S_HB0 || f_irq_v != 6) begin
      bad++; $display("FAIL irq_6 n=%0d at h=%0d v=%0d exp 1 at 31/6", f_irq_n, f_irq_h, f_irq_v);
    end
    run_frame(-1, 9'd0);
    total++; if (f_irq_n != 0) begin bad++; $display("FAIL irq_out_of_range n=%0d exp=0", f_irq_n); end
`else
    total++; if (f_irq_n != 0) begin bad++; $display("FAIL irq_disabled n=%0d exp=0", f_irq_n); end
`endif
  endtask

  task automatic test_reset_pulse();
`ifdef JTKICKER_VTGEN_LINEIRQ_EN
    int n = 0;
    do_reset();
    // shadow is 0 after reset, so the pulse arrives on line 0
    while (small_if.line_irq !== 1'b1 && n < 100) begin
      small_step();
      n++;
    end
    total++;
    if (small_if.line_irq !== 1'b1) begin
      bad++; $display("FAIL rst_pulse_arm got=%b exp=1", small_if.line_irq);
    end else begin
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (small_if.line_irq !== 1'b0) begin bad++; $display("FAIL rst_pulse_clear got=%b exp=0", small_if.line_irq); end
    end
    do_reset();
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    big_if.pxl_cen = 1'b0;   big_if.flip = 1'b0;   big_if.irq_line = 9'd0;
    small_if.pxl_cen = 1'b0; small_if.flip = 1'b0; small_if.irq_line = 9'd0;
    model_reset();
    test_reset();
    test_hcount();
    test_hsync();
    test_hold_flip();
    test_frame();
    test_reset_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtkicker_vtgen.md
JTKICKER_VTGEN -- requirements
Module: jtkicker_vtgen

Interface
REQ-001 SHALL have parameter W, 9, width of all counters and compare values.
REQ-002 SHALL have parameter HCNT_END, 383, last hdump value; VCNT_END, 263, last vdump value.
REQ-003 SHALL have parameters HB_START 255, HB_END 383, HS_START 300, HS_END 318: inclusive horizontal blank and sync windows.
REQ-004 SHALL have parameters VB_START 239, VB_END 15, VS_START 254, VS_END 2: inclusive vertical blank and sync windows.
REQ-005 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: pxl_cen in 1 pixel enable; flip in 1 screen flip; irq_line in W line-interrupt target.
REQ-007 SHALL have ports: hdump out W; vdump out W; vrender out W (next line); vdump_f out W (flip-adjusted vdump).
REQ-008 SHALL have ports: hinit, vinit, LHBL, LVBL, HS, VS, line_irq, all out 1.

Function
REQ-009 All state SHALL advance only on clk edges with pxl_cen=1; with pxl_cen=0 every output SHALL hold.
REQ-010 hdump SHALL count 0..HCNT_END, then wrap to 0; vdump SHALL increment only on hdump wrap, 0..VCNT_END, then wrap to 0.
REQ-011 vrender SHALL equal vdump+1, and 0 when vdump==VCNT_END; it SHALL be updated in the same cycle as vdump.
REQ-012 hinit SHALL be 1 exactly while hdump==HCNT_END; vinit SHALL be 1 exactly while hinit=1 and vdump==VCNT_END.
REQ-013 Every window [START,END] SHALL be inclusive; if START>END, it SHALL wrap through 0; if START==END, it SHALL be one count wide.
REQ-014 LHBL SHALL be 0 while hdump is in the HB window; LVBL SHALL be 0 while vdump is in the VB window; both registered, aligned to the counter value shown.
REQ-015 HS SHALL be 1 while hdump is in the HS window; VS SHALL change state only in the cycle hdump becomes HS_START; it SHALL then take vdump-in-VS-window.
REQ-016 vdump_f SHALL equal ~vdump when flip=1, else vdump; it SHALL be combinational from flip.
REQ-017 irq_line SHALL be copied to a shadow register on every vinit cycle; compares SHALL use only the shadow.
REQ-018 line_irq SHALL pulse high for exactly one clk when hdump becomes HB_START and vdump equals the shadow.
REQ-019 If the shadow is greater than VCNT_END, line_irq SHALL never fire.
REQ-020 A change of irq_line mid-frame SHALL take effect from the next frame.

Reset
REQ-021 While rst_n=0: hdump=0, vdump=0, vrender=1, shadow=0, hinit=vinit=0, LHBL=LVBL=0, HS=VS=0, line_irq=0.
REQ-022 Reset SHALL act asynchronously on assertion; the first pxl_cen after release SHALL produce hdump=1.
REQ-023 Reset asserted mid-pulse SHALL clear line_irq immediately.

Configuration
REQ-024 With JTKICKER_VTGEN_LINEIRQ_EN defined, the shadow register and line_irq logic SHALL be built.
REQ-025 Without JTKICKER_VTGEN_LINEIRQ_EN, line_irq SHALL be tied to 0 and irq_line ignored, with no shadow register.

Structure
REQ-026 Package jtkicker_vtgen_pkg SHALL hold the default timing constants (384x264 set above) and a window-test function, inclusive and wrap-aware.
REQ-027 Sub-module jtkicker_vtgen_cnt SHALL implement one wrapping counter with end-of-count flag; it SHALL be instantiated twice (H, V).

Verification
REQ-028 Reset, 383 pxl_cen -> hdump=383, hinit=1; next pxl_cen -> hdump=0, vdump=1, vrender=2.
REQ-029 Run a full frame (384*264 pxl_cen) -> vinit high once, at hdump=383 and vdump=263; LVBL=0 exactly for vdump 239..263 and 0..15.
REQ-030 Check HS: high for hdump 300..318 (19 counts) per line; VS rises only at hdump=300 of vdump=254 and falls at hdump=300 of vdump=3.
REQ-031 With LINEIRQ_EN, set irq_line=100 before a frame -> one-clk line_irq at vdump=100, hdump=255; set irq_line=300 -> no pulse.
REQ-032 Change irq_line 100->50 at vdump=80 -> pulse still at 100 this frame, at 50 next frame.
REQ-033 Hold pxl_cen=0 for 10 clks mid-line -> all outputs constant; flip=1 at vdump=16 -> vdump_f=495 (9-bit).
